// File: rtl/fp32_pkg.sv
// Shared IEEE-754 single-precision constants, field widths and divider FSM types.
package fp32_pkg;

    localparam int unsigned W     = 32;
    localparam int unsigned E_W   = 8;
    localparam int unsigned F_W   = 23;
    localparam int unsigned M_W   = 24;
    localparam int unsigned Q_W   = 25;
    localparam int unsigned EXP_W = 10;
    localparam int unsigned CNT_W = 5;
    localparam int unsigned BIAS  = 127;

    localparam logic [W-1:0]   QNAN    = 32'h7FC0_0000;
    localparam logic [E_W-1:0] EXP_MAX = 8'hFF;

    localparam logic signed [EXP_W-1:0] EXP_OVF  = 10'sd255;
    localparam logic signed [EXP_W-1:0] EXP_ZERO = 10'sd0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV  = 2'd1,
        NORM = 2'd2,
        DONE = 2'd3
    } state_t;

    typedef struct packed {
        logic invalid;
        logic div_by_zero;
        logic overflow;
        logic underflow;
    } flags_t;

    typedef struct packed {
        logic [W-1:0] q;
        flags_t       flags;
    } result_t;

endpackage

// File: rtl/number_detect.sv
// Splits an IEEE-754 single into fields and classifies it; denormals read as signed zero.
module number_detect
    import fp32_pkg::*;
(
    input  logic [W-1:0]   x,
    output logic           sign_c,
    output logic [E_W-1:0] exp_c,
    output logic [M_W-1:0] man_c,
    output logic           is_zero_c,
    output logic           is_inf_c,
    output logic           is_nan_c
);

    logic [F_W-1:0] frac;

    assign sign_c    = x[W-1];
    assign exp_c     = x[W-2 -: E_W];
    assign frac      = x[F_W-1:0];
    assign man_c     = {1'b1, frac};
    // A zero exponent is treated as zero regardless of the fraction (flush-to-zero).
    assign is_zero_c = (exp_c == '0);
    assign is_inf_c  = (exp_c == EXP_MAX) && (frac == '0);
    assign is_nan_c  = (exp_c == EXP_MAX) && (frac != '0);

endmodule

// File: rtl/fp32_divider.sv
// Multi-cycle FP32 divider: radix-2 restoring mantissa division, truncating rounding.
module fp32_divider
    import fp32_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] q,
    output logic         invalid,
    output logic         div_by_zero,
    output logic         overflow,
    output logic         underflow
);

    state_t state_q, state_d;

    logic           sign_a, sign_b, zero_a, zero_b, inf_a, inf_b, nan_a, nan_b;
    logic [E_W-1:0] exp_a, exp_b;
    logic [M_W-1:0] man_a, man_b;

    logic [Q_W-1:0]          rem_q;
    logic [M_W-1:0]          div_q;
    logic [Q_W-1:0]          quo_q;
    logic [CNT_W-1:0]        cnt_q;
    logic signed [EXP_W-1:0] exp_q;
    logic                    sign_q;
    result_t                 res_q;

    logic                    special_c, sign_ab_c, ge_c;
    logic [M_W-1:0]          rem_diff_c;
    logic signed [EXP_W-1:0] exp_init_c, exp_norm_c;
    logic [F_W-1:0]          mant_norm_c;
    result_t                 spec_res_c, norm_res_c;

    number_detect u_det_a (
        .x(a), .sign_c(sign_a), .exp_c(exp_a), .man_c(man_a),
        .is_zero_c(zero_a), .is_inf_c(inf_a), .is_nan_c(nan_a)
    );

    number_detect u_det_b (
        .x(b), .sign_c(sign_b), .exp_c(exp_b), .man_c(man_b),
        .is_zero_c(zero_b), .is_inf_c(inf_b), .is_nan_c(nan_b)
    );

    // Special-operand result, resolved in the acceptance cycle.
    always_comb begin
        sign_ab_c  = sign_a ^ sign_b;
        special_c  = nan_a | nan_b | zero_a | zero_b | inf_a | inf_b;
        exp_init_c = EXP_W'(exp_a) - EXP_W'(exp_b) + EXP_W'(BIAS);
        spec_res_c = '0;
        if (nan_a || nan_b || (zero_a && zero_b) || (inf_a && inf_b)) begin
            spec_res_c.q             = QNAN;
            spec_res_c.flags.invalid = 1'b1;
        end else if (inf_a) begin
            spec_res_c.q = {sign_ab_c, EXP_MAX, F_W'(0)};
        end else if (inf_b) begin
            spec_res_c.q = {sign_ab_c, (W-1)'(0)};
        end else if (zero_b) begin
            spec_res_c.q                 = {sign_ab_c, EXP_MAX, F_W'(0)};
            spec_res_c.flags.div_by_zero = 1'b1;
        end else begin
            spec_res_c.q = {sign_ab_c, (W-1)'(0)};
        end
    end

    // One restoring step; the remainder stays below twice the divisor.
    always_comb begin
        ge_c       = (rem_q >= {1'b0, div_q});
        rem_diff_c = M_W'(rem_q - {1'b0, div_q});
    end

    // Normalise the 25-bit quotient and range-check the exponent.
    always_comb begin
        exp_norm_c  = quo_q[Q_W-1] ? exp_q : exp_q - EXP_W'(1);
        mant_norm_c = quo_q[Q_W-1] ? quo_q[Q_W-2:1] : quo_q[Q_W-3:0];
        norm_res_c  = '0;
        if (exp_norm_c >= EXP_OVF) begin
            norm_res_c.q              = {sign_q, EXP_MAX, F_W'(0)};
            norm_res_c.flags.overflow = 1'b1;
        end else if (exp_norm_c <= EXP_ZERO) begin
            norm_res_c.q               = {sign_q, (W-1)'(0)};
            norm_res_c.flags.underflow = 1'b1;
        end else begin
            norm_res_c.q = {sign_q, exp_norm_c[E_W-1:0], mant_norm_c};
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = special_c ? DONE : DIV;
            DIV:     if (cnt_q == CNT_W'(Q_W - 1)) state_d = NORM;
            NORM:    state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Datapath and registered outputs; q/flags only move when done is raised.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy        <= 1'b0;
            done        <= 1'b0;
            q           <= '0;
            invalid     <= 1'b0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
            underflow   <= 1'b0;
            rem_q       <= '0;
            div_q       <= '0;
            quo_q       <= '0;
            cnt_q       <= '0;
            exp_q       <= '0;
            sign_q      <= 1'b0;
            res_q       <= '0;
        end else begin
            busy <= (state_d != IDLE);
            done <= (state_q == DONE);
            case (state_q)
                IDLE: begin
                    if (start) begin
                        rem_q  <= {1'b0, man_a};
                        div_q  <= man_b;
                        quo_q  <= '0;
                        cnt_q  <= '0;
                        exp_q  <= exp_init_c;
                        sign_q <= sign_ab_c;
                        if (special_c) res_q <= spec_res_c;
                    end
                end
                DIV: begin
                    quo_q <= {quo_q[Q_W-2:0], ge_c};
                    rem_q <= ge_c ? {rem_diff_c, 1'b0} : {rem_q[Q_W-2:0], 1'b0};
                    cnt_q <= cnt_q + CNT_W'(1);
                end
                NORM: res_q <= norm_res_c;
                DONE: begin
                    q           <= res_q.q;
                    invalid     <= res_q.flags.invalid;
                    div_by_zero <= res_q.flags.div_by_zero;
                    overflow    <= res_q.flags.overflow;
                    underflow   <= res_q.flags.underflow;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fp32_divider.sv
// Scoreboard bench for fp32_divider: directed vectors, latency and flag checks.
module tb_fp32_divider;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] a, b;
    logic        busy, done;
    logic [31:0] q;
    logic        invalid, div_by_zero, overflow, underflow;

    typedef struct {
        string       name;
        logic [31:0] q;
        logic [3:0]  flags;
        int unsigned cyc;
    } exp_t;

    typedef struct {
        string       name;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
        logic [3:0]  flags;
        int unsigned lat;
    } vec_t;

    exp_t        sb[$];
    vec_t        vecs[$];
    int unsigned cyc = 0;
    int          checks = 0;
    int          errors = 0;

    localparam logic [3:0] F_NONE = 4'b0000;
    localparam logic [3:0] F_INV  = 4'b1000;
    localparam logic [3:0] F_DBZ  = 4'b0100;
    localparam logic [3:0] F_OVF  = 4'b0010;
    localparam logic [3:0] F_UNF  = 4'b0001;
    localparam int unsigned LAT_FIN = 27;
    localparam int unsigned LAT_SPC = 1;

    fp32_divider dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
        .busy(busy), .done(done), .q(q), .invalid(invalid),
        .div_by_zero(div_by_zero), .overflow(overflow), .underflow(underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && done === 1'b1) begin
            exp_t e;
            logic [3:0] got_f;
            got_f = {invalid, div_by_zero, overflow, underflow};
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_done: q=%h flags=%b at cycle %0d, no result pending", q, got_f, cyc);
            end else begin
                e = sb.pop_front();
                if (q !== e.q || got_f !== e.flags || cyc != e.cyc)
                begin
                    errors++;
                    $display("FAIL %s: got q=%h flags=%b cycle=%0d, expected q=%h flags=%b cycle=%0d",
                             e.name, q, got_f, cyc, e.q, e.flags, e.cyc);
                end
            end
        end
    end

    task automatic check_bit(input string name, input logic got, input logic want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %b, expected %b", name, got, want);
        end
    endtask

    task automatic check_zero_outputs(input string tag);
        check_bit({tag, "_busy"}, busy, 1'b0);
        check_bit({tag, "_done"}, done, 1'b0);
        check_bit({tag, "_flags"}, |{invalid, div_by_zero, overflow, underflow}, 1'b0);
        checks++;
        if (q !== 32'h0) begin
            errors++;
            $display("FAIL %s_q: got %h, expected 00000000", tag, q);
        end
    endtask

    // Called at a negedge: start is sampled at the next posedge.
    task automatic start_op(input string name, input logic [31:0] va, input logic [31:0] vb,
                            input logic [31:0] vq, input logic [3:0] vf, input int unsigned lat);
        a     = va;
        b     = vb;
        start = 1'b1;
        sb.push_back('{name, vq, vf, cyc + 1 + lat});
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while (sb.size() != 0 && n < 80) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got %0d results pending, expected 0", name, sb.size());
            sb.delete();
        end
    endtask

    initial begin
        vecs.push_back('{"six_div_two",   32'h40C00000, 32'h40000000, 32'h40400000, F_NONE, LAT_FIN});
        vecs.push_back('{"one_div_three", 32'h3F800000, 32'h40400000, 32'h3EAAAAAA, F_NONE, LAT_FIN});
        vecs.push_back('{"one_div_one",   32'h3F800000, 32'h3F800000, 32'h3F800000, F_NONE, LAT_FIN});
        vecs.push_back('{"one_div_1p5",   32'h3F800000, 32'h3FC00000, 32'h3F2AAAAA, F_NONE, LAT_FIN});
        vecs.push_back('{"max_div_one",   32'h7F7FFFFF, 32'h3F800000, 32'h7F7FFFFF, F_NONE, LAT_FIN});
        vecs.push_back('{"min_norm_res",  32'h01000000, 32'h40000000, 32'h00800000, F_NONE, LAT_FIN});
        vecs.push_back('{"overflow",      32'h7F000000, 32'h3E800000, 32'h7F800000, F_OVF,  LAT_FIN});
        vecs.push_back('{"underflow",     32'h00800000, 32'h40000000, 32'h00000000, F_UNF,  LAT_FIN});
        vecs.push_back('{"unf_via_norm",  32'h00800000, 32'h3F800001, 32'h00000000, F_UNF,  LAT_FIN});
        vecs.push_back('{"x_div_zero",    32'h3F800000, 32'h00000000, 32'h7F800000, F_DBZ,  LAT_SPC});
        vecs.push_back('{"zero_div_zero", 32'h00000000, 32'h00000000, 32'h7FC00000, F_INV,  LAT_SPC});
        vecs.push_back('{"inf_div_inf",   32'h7F800000, 32'hFF800000, 32'h7FC00000, F_INV,  LAT_SPC});
        vecs.push_back('{"nan_operand",   32'h7FC00001, 32'h3F800000, 32'h7FC00000, F_INV,  LAT_SPC});
        vecs.push_back('{"inf_div_x",     32'hFF800000, 32'h40000000, 32'hFF800000, F_NONE, LAT_SPC});
        vecs.push_back('{"x_div_inf",     32'h3F800000, 32'hFF800000, 32'h80000000, F_NONE, LAT_SPC});
        vecs.push_back('{"zero_div_x",    32'h80000000, 32'h40000000, 32'h80000000, F_NONE, LAT_SPC});
        vecs.push_back('{"denorm_a",      32'h00000001, 32'h3F800000, 32'h00000000, F_NONE, LAT_SPC});
        vecs.push_back('{"denorm_b",      32'h3F800000, 32'h80000001, 32'hFF800000, F_DBZ,  LAT_SPC});

        rst_n = 1'b0;
        start = 1'b0;
        a     = '0;
        b     = '0;
        repeat (3) @(negedge clk);
        check_zero_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);

        foreach (vecs[i]) begin
            start_op(vecs[i].name, vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].flags, vecs[i].lat);
            check_bit({vecs[i].name, "_busy"}, busy, 1'b1);
            wait_drain(vecs[i].name);
        end

        // Back-to-back: second start in the first IDLE cycle after DONE.
        start_op("b2b_first", 32'h40C00000, 32'h40000000, 32'h40400000, F_NONE, LAT_FIN);
        repeat (LAT_FIN) @(negedge clk);
        check_bit("b2b_idle_busy", busy, 1'b0);
        start_op("b2b_second", 32'h3F800000, 32'h3FC00000, 32'h3F2AAAAA, F_NONE, LAT_FIN);
        wait_drain("b2b");

        // Reset mid-DIV aborts with no done pulse.
        a     = 32'h40C00000;
        b     = 32'h40000000;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check_zero_outputs("abort");
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        start_op("after_abort", 32'hC0C00000, 32'h40000000, 32'hC0400000, F_NONE, LAT_FIN);
        wait_drain("after_abort");

        // Start held high throughout; operand changes after capture have no effect.
        begin
            bit seen = 1'b0;
            a     = 32'h40C00000;
            b     = 32'h40000000;
            start = 1'b1;
            sb.push_back('{"held_start", 32'h40400000, F_NONE, cyc + 1 + LAT_FIN});
            for (int n = 0; n < 60 && !seen; n++) begin
                @(negedge clk);
                if (n == 10) begin
                    a = 32'h7FC00000;
                    b = 32'h00000000;
                end
                if (done === 1'b1) seen = 1'b1;
            end
            start = 1'b0;
            if (!seen) begin
                checks++;
                errors++;
                $display("FAIL held_start_timeout: got no done, expected one within 60 cycles");
                sb.delete();
            end
            repeat (60) @(negedge clk);
        end

        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL final_queue: got %0d results pending, expected 0", sb.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
